// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary: ALU op codes, exception FSM states
// and the default overflow handler vector.
package ex_mem_stage_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MOVE = 3'b010;
  localparam logic [2:0] ALU_SWAP = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;

  localparam logic [15:0] EXC_VECTOR_DEFAULT = 16'h0040;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StHold  = 2'd2
  } exc_state_e;

  // Only ADD and SUB may raise an overflow exception.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/ex_mem_stage_exc_ctrl.sv
// Overflow exception control: IDLE/FLUSH/HOLD FSM, EPC capture, sticky pending flag and a
// saturating event counter.
module ex_mem_stage_exc_ctrl
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned    DW         = 16,
  parameter int unsigned    CNT_W      = 8,
  parameter logic [DW-1:0]  EXC_VECTOR = DW'(EXC_VECTOR_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  input  logic             trap_i,
  input  logic             ack_i,
  input  logic [DW-1:0]    pc_i,
  output logic             exc_flush_o,
  output logic [DW-1:0]    exc_redirect_pc_o,
  output logic             exc_pending_o,
  output logic [DW-1:0]    exc_epc_o,
  output logic [CNT_W-1:0] exc_count_o
);

  exc_state_e       state_q, state_d;
  logic             pending_q, pending_d;
  logic [DW-1:0]    epc_q, epc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ack_seen_q, ack_seen_d;
  logic             flush;

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    epc_d      = epc_q;
    count_d    = count_q;
    ack_seen_d = ack_seen_q;
    flush      = 1'b0;
    if (!advance_i) begin
      // An ack seen while stalled is remembered and acted on once the stall releases.
      if (ack_i && (state_q == StHold)) ack_seen_d = 1'b1;
    end else begin
      ack_seen_d = 1'b0;
      if (trap_i && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
      unique case (state_q)
        StIdle: begin
          if (trap_i) begin
            state_d   = StFlush;
            pending_d = 1'b1;
            epc_d     = pc_i;
          end
        end
        StFlush: begin
          flush   = 1'b1;
          state_d = StHold;
        end
        StHold: begin
          if (ack_i || ack_seen_q) begin
            state_d   = StIdle;
            pending_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      epc_q      <= '0;
      count_q    <= '0;
      ack_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      ack_seen_q <= ack_seen_d;
    end
  end

  assign exc_flush_o       = flush;
  assign exc_redirect_pc_o = flush ? EXC_VECTOR : '0;
  assign exc_pending_o     = pending_q;
  assign exc_epc_o         = epc_q;
  assign exc_count_o       = count_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: splits the packed SWAP result, squashes overflow-trapped
// instructions and hosts the exception controller.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned   DW         = 16,
  parameter int unsigned   RW         = 4,
  parameter logic [DW-1:0] EXC_VECTOR = DW'(EXC_VECTOR_DEFAULT),
  parameter int unsigned   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic [DW-1:0]    ex_pc,
  input  logic [2:0]       ex_alu_ctrl,
  input  logic [2*DW-1:0]  ex_result,
  input  logic             ex_overflow,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [RW-1:0]    ex_rd,
  input  logic [RW-1:0]    ex_rs,
  input  logic [DW-1:0]    ex_store_data,
  input  logic             exc_ack,
  output logic             mem_valid,
  output logic [DW-1:0]    mem_result,
  output logic [DW-1:0]    mem_swap_data,
  output logic             mem_swap_we,
  output logic             mem_reg_write,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic [RW-1:0]    mem_rd,
  output logic [RW-1:0]    mem_rs,
  output logic [DW-1:0]    mem_store_data,
  output logic             exc_flush,
  output logic [DW-1:0]    exc_redirect_pc,
  output logic             exc_pending,
  output logic [DW-1:0]    exc_epc,
  output logic [CNT_W-1:0] exc_count
);

  logic advance, trap, keep;

  assign advance = ~stall;
  assign trap    = advance & ex_valid & ex_overflow & is_arith(ex_alu_ctrl);
  // A trapped instruction still moves its data but loses every write/enable.
  assign keep    = ex_valid & ~trap;

  logic          valid_q, valid_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] swap_data_q, swap_data_d;
  logic          swap_we_q, swap_we_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [DW-1:0] store_data_q, store_data_d;

  always_comb begin
    valid_d      = valid_q;
    result_d     = result_q;
    swap_data_d  = swap_data_q;
    swap_we_d    = swap_we_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    store_data_d = store_data_q;
    if (advance) begin
      valid_d      = keep;
      result_d     = ex_result[DW-1:0];
      swap_we_d    = keep & ex_reg_write & (ex_alu_ctrl == ALU_SWAP);
      swap_data_d  = swap_we_d ? ex_result[2*DW-1:DW] : '0;
      reg_write_d  = keep & ex_reg_write;
      mem_read_d   = keep & ex_mem_read;
      mem_write_d  = keep & ex_mem_write;
      rd_d         = ex_rd;
      rs_d         = ex_rs;
      store_data_d = ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      swap_data_q  <= '0;
      swap_we_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      rd_q         <= '0;
      rs_q         <= '0;
      store_data_q <= '0;
    end else begin
      valid_q      <= valid_d;
      result_q     <= result_d;
      swap_data_q  <= swap_data_d;
      swap_we_q    <= swap_we_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      rd_q         <= rd_d;
      rs_q         <= rs_d;
      store_data_q <= store_data_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_swap_data  = swap_data_q;
  assign mem_swap_we    = swap_we_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_rd         = rd_q;
  assign mem_rs         = rs_q;
  assign mem_store_data = store_data_q;

  ex_mem_stage_exc_ctrl #(
    .DW        (DW),
    .CNT_W     (CNT_W),
    .EXC_VECTOR(EXC_VECTOR)
  ) u_exc_ctrl (
    .clk              (clk),
    .rst_n            (rst_n),
    .advance_i        (advance),
    .trap_i           (trap),
    .ack_i            (exc_ack),
    .pc_i             (ex_pc),
    .exc_flush_o      (exc_flush),
    .exc_redirect_pc_o(exc_redirect_pc),
    .exc_pending_o    (exc_pending),
    .exc_epc_o        (exc_epc),
    .exc_count_o      (exc_count)
  );

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
EX/MEM pipeline boundary of the 5-stage datapath. Registers the main ALU's 32-bit result, overflow flag and EX-stage control into the MEM stage. Splits the packed SWAP result into primary and secondary writeback data. Owns arithmetic-overflow exception handling: squash, EPC capture, one-cycle pipeline flush/redirect, and a sticky status held until acknowledged.

Parameters:
DW, 16, datapath word width; the ALU result is 2*DW
RW, 4, register-index width
EXC_VECTOR, 16'h0040, PC of the overflow handler, driven on redirect
CNT_W, 8, width of the saturating overflow event counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold all EX/MEM registers (MEM-stage back-pressure)
ex_valid  in  1  EX holds a real instruction
ex_pc  in  DW  PC of the EX instruction
ex_alu_ctrl  in  3  ALU op (000 ADD, 001 SUB, 010 MOVE, 011 SWAP, 100 AND, 101-111 OR)
ex_result  in  2*DW  ALU result; [DW-1:0] primary, [2*DW-1:DW] swap data
ex_overflow  in  1  ALU overflow flag
ex_reg_write  in  1  instruction writes rd
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_rd  in  RW  primary destination
ex_rs  in  RW  second destination, for SWAP
ex_store_data  in  DW  store data
exc_ack  in  1  handler done; clears the sticky exception
mem_valid  out  1  MEM holds a real instruction
mem_result  out  DW  primary result / address
mem_swap_data  out  DW  secondary write data
mem_swap_we  out  1  write mem_swap_data to mem_rs
mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control
mem_rd, mem_rs  out  RW  registered destinations
mem_store_data  out  DW  registered store data
exc_flush  out  1  one-cycle flush of IF/ID/EX
exc_redirect_pc  out  DW  equals EXC_VECTOR when exc_flush=1, else 0
exc_pending  out  1  sticky overflow exception active
exc_epc  out  DW  PC of the faulting instruction
exc_count  out  CNT_W  saturating count of overflow events

Behaviour:
- Reset (async, rst_n=0): every output is 0; FSM goes to IDLE. Reset mid-exception abandons it with no residue.
- Advance = ~stall. When stall=1, all mem_* and exc_* registers hold, no FSM transition occurs, and exc_flush is forced to 0. exc_ack is still sampled and is handled after the stall releases.
- Overflow trap (trap) = advance & ex_valid & ex_overflow & (ex_alu_ctrl is 000 or 001). ex_overflow under any other op is ignored.
- Normal advance: all mem_* outputs take the ex_* values on the next edge. Latency is 1 cycle.
  - mem_result = ex_result[DW-1:0].
  - mem_swap_data = ex_result[2*DW-1:DW].
  - mem_swap_we = ex_valid & ex_reg_write & (ex_alu_ctrl==011). It is 0 for every other op, and mem_swap_data is then 0.
  - If ex_valid=0, mem_valid and all write/enable controls load 0.
- Trap advance: the faulting instruction is squashed. mem_valid, mem_reg_write, mem_mem_read, mem_mem_write and mem_swap_we load 0.
- FSM states: IDLE, FLUSH, HOLD.
  - IDLE, trap: go to FLUSH. exc_epc<=ex_pc, exc_pending<=1, exc_count increments.
  - FLUSH: lasts exactly 1 cycle with exc_flush=1 and exc_redirect_pc=EXC_VECTOR, then goes to HOLD. A stall during FLUSH extends it; the flush is asserted on the first unstalled cycle.
  - HOLD: the pipeline runs normally with exc_pending=1. A trap here squashes the instruction and increments exc_count, but exc_epc is kept and no new flush is issued.
  - HOLD, exc_ack: go to IDLE with exc_pending<=0.
  - exc_ack in IDLE or FLUSH is ignored.
  - exc_ack and a trap in the same cycle in HOLD: the ack wins and the trap counts only.
- exc_count saturates at all-ones and clears only on reset.

Decomposition:
- Shared package:
  - ALU op encodings (ALU_ADD..ALU_OR)
  - FSM state typedef
  - EXC_VECTOR default
- One natural sub-module, exc_ctrl: the FSM, EPC, sticky flag and saturating counter, driven by trap/advance/exc_ack.
- The pipeline register stays in the top module.

Test Plan:
- ADD, ex_result=32'h0000_1234, rd=3, reg_write=1, no stall -> next cycle mem_valid=1, mem_result=16'h1234, mem_rd=3, mem_swap_we=0.
- SWAP, ex_result=32'hAAAA_5555, rd=1, rs=2 -> mem_result=16'h5555, mem_swap_data=16'hAAAA, mem_swap_we=1, mem_rs=2.
- ADD with ex_overflow=1, ex_pc=16'h0010 -> MEM writes all 0; next cycle exc_flush=1, exc_redirect_pc=16'h0040; then exc_epc=16'h0010, exc_pending=1, exc_count=1; exc_ack -> pending=0.
- MOVE with ex_overflow=1 -> no trap; normal writeback, exc_count stays 0.
- Overflow presented with stall=1 for 3 cycles -> no flush and outputs hold; trap taken on the first stall=0 cycle.
- A second overflow in HOLD at pc 16'h0044 -> exc_epc stays 16'h0010 and exc_count=2. 300 traps -> count=8'hFF. rst_n pulsed in FLUSH -> all outputs 0.
